// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with a fixed access latency, little-endian byte lanes,
// load extension and misalignment/range/encoding fault checks; one transaction in flight.
module dmem_responder #(
  parameter int XLEN      = 32,
  parameter int DMEM_SIZE = 1024,
  parameter int LATENCY   = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);
  localparam int AW    = $clog2(DMEM_SIZE);
  localparam int WORDS = DMEM_SIZE / 4;
  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_we, r_err;
  logic [2:0]      r_f3;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [31:0]     r_mem [WORDS];

  logic            w_acc, w_we, w_half, w_full, w_mis, w_ill, w_oor, w_err;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_addr, w_wdata, w_rdata;
  logic [AW-3:0]   w_idx;
  logic [31:0]     w_word, w_wd;
  logic [3:0]      w_be;
  logic [7:0]      w_b;
  logic [15:0]     w_h;

  assign req_ready_o = r_state == IDLE;
  assign rsp_valid_o = r_state == RESP;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;

  // With LATENCY==1 the access happens on the accept edge, so operands come straight from the request port
  assign w_acc   = rst_ni && ((r_state == IDLE && req_valid_i && LATENCY == 1) ||
                              (r_state == WAIT && r_cnt == 4'd1));
  assign w_we    = r_state == IDLE ? req_we_i     : r_we;
  assign w_f3    = r_state == IDLE ? req_funct3_i : r_f3;
  assign w_addr  = r_state == IDLE ? req_addr_i   : r_addr;
  assign w_wdata = r_state == IDLE ? req_wdata_i  : r_wdata;

  assign w_idx  = w_addr[AW-1:2];
  assign w_word = r_mem[w_idx];
  assign w_b    = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_h    = w_word[{w_addr[1], 4'b0000} +: 16];

  assign w_half = w_f3 == FUNCT3_LH || w_f3 == FUNCT3_LHU;
  assign w_full = w_f3 == FUNCT3_LW;
  assign w_mis  = (w_half && w_addr[0]) || (w_full && w_addr[1:0] != 2'b00);
  assign w_oor  = w_addr >= XLEN'(DMEM_SIZE);
  assign w_ill  = w_we ? !(w_f3 == FUNCT3_SB || w_f3 == FUNCT3_SH || w_f3 == FUNCT3_SW)
                       : !(w_f3 == FUNCT3_LB || w_f3 == FUNCT3_LH || w_f3 == FUNCT3_LW ||
                           w_f3 == FUNCT3_LBU || w_f3 == FUNCT3_LHU);
  assign w_err  = w_mis || w_oor || w_ill;

  assign w_rdata = (w_we || w_err)       ? '0 :
                   w_f3 == FUNCT3_LW     ? XLEN'(w_word) :
                   w_f3 == FUNCT3_LH     ? {{(XLEN-16){w_h[15]}}, w_h} :
                   w_f3 == FUNCT3_LHU    ? XLEN'(w_h) :
                   w_f3 == FUNCT3_LB     ? {{(XLEN-8){w_b[7]}}, w_b} : XLEN'(w_b);

  assign w_be = w_f3 == FUNCT3_SW ? 4'b1111 :
                w_f3 == FUNCT3_SH ? 4'b0011 << {w_addr[1], 1'b0} : 4'b0001 << w_addr[1:0];
  assign w_wd = w_f3 == FUNCT3_SW ? w_wdata[31:0] :
                w_f3 == FUNCT3_SH ? {2{w_wdata[15:0]}} : {4{w_wdata[7:0]}};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = req_valid_i ? (LATENCY == 1 ? RESP : WAIT) : IDLE;
      WAIT:    w_state_nxt = r_cnt == 4'd1 ? RESP : WAIT;
      RESP:    w_state_nxt = rsp_ready_i ? IDLE : RESP;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && req_valid_i) begin
        r_we    <= req_we_i;
        r_f3    <= req_funct3_i;
        r_addr  <= req_addr_i;
        r_wdata <= req_wdata_i;
        r_cnt   <= 4'(LATENCY - 1);
      end
      if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_acc) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end else if (r_state == RESP && rsp_ready_i) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Storage is not reset; stores land on the same edge the response is produced
  always_ff @(posedge clk_i) begin
    if (w_acc && w_we && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
  end
endmodule
